tsoip_dgram_sched: RTL and testbench

TSOIP_DGRAM_SCHED -- requirements
Module: tsoip_dgram_sched

---
 rtl/tsoip_dgram_sched_if.sv | 17 +
 rtl/tsoip_dgram_sched.sv | 242 ++++++++++++++++++++++++
 tb/tb_tsoip_dgram_sched.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tsoip_dgram_sched_if.sv
// tsoip_dgram_sched_if: byte stream produced by the datagram scheduler.
//   o_Data     output byte
//   o_Valid    o_Data carries a datagram byte
//   o_Sync     first byte of a datagram
//   o_End      last byte of a datagram
//   o_Stuffed  with o_End: the datagram carried at least one null packet
// master = scheduler side, slave = consumer side.
interface tsoip_dgram_sched_if;
  logic [7:0] o_Data;
  logic       o_Valid;
  logic       o_Sync;
  logic       o_End;
  logic       o_Stuffed;

  modport master (output o_Data, o_Valid, o_Sync, o_End, o_Stuffed);
  modport slave  (input  o_Data, o_Valid, o_Sync, o_End, o_Stuffed);
endinterface

// File: rtl/tsoip_dgram_sched.sv
// tsoip_dgram_sched: assembles TS-over-IP datagrams from NUM_CH TS FIFOs.
// A datagram is an HDR_LEN-byte header read from an external header RAM,
// followed by exactly K TS packets; packets the granted FIFO cannot supply
// are replaced by null packets. Channels are picked round-robin once they
// hold K packets, or on a flush timeout once they hold at least one.
// Ports:
//   i_Clk, i_Rst      clock, synchronous active-high reset
//   i_Enable          allows new grants
//   i_NumPkt          packets per datagram (0 -> 1, clamped to MAX_PKTS)
//   i_PktLen          bytes per TS packet
//   i_Timeout         flush timeout in cycles, 0 disables flushing
//   i_Level           packed per-channel FIFO levels
//   i_HdrData         header RAM q (1-cycle latency)
//   i_PayData         selected FIFO q (1-cycle latency)
//   o_Chan            granted channel (steers header RAM and payload mux)
//   o_RdHdr/o_HdrAddr header RAM read enable / address
//   o_RdPay           one-hot FIFO read request
//   dgramOut          output byte stream (see tsoip_dgram_sched_if)
module tsoip_dgram_sched #(
  parameter  int NUM_CH   = 2,
  parameter  int LVL_W    = 11,
  parameter  int HDR_LEN  = 42,
  parameter  int MAX_PKTS = 7,
  parameter  int IFG      = 12,
  parameter  int TMO_W    = 16,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Enable,
  input  logic [2:0]              i_NumPkt,
  input  logic [7:0]              i_PktLen,
  input  logic [TMO_W-1:0]        i_Timeout,
  input  logic [NUM_CH*LVL_W-1:0] i_Level,
  input  logic [7:0]              i_HdrData,
  input  logic [7:0]              i_PayData,
  output logic [CH_W-1:0]         o_Chan,
  output logic                    o_RdHdr,
  output logic [5:0]              o_HdrAddr,
  output logic [NUM_CH-1:0]       o_RdPay,
  tsoip_dgram_sched_if.master     dgramOut
);

  localparam int NEED_W = LVL_W + 3;
  localparam int REM_W  = (LVL_W > 8) ? LVL_W : 8;

  typedef enum logic [2:0] {IDLE, HDR, PAY, NUL, GAP} stateT;
  typedef enum logic [1:0] {SRC_NONE, SRC_HDR, SRC_PAY, SRC_NUL} srcT;

  stateT stateQ, stateNext;

  logic [LVL_W-1:0]  lvl [NUM_CH];
  logic [TMO_W-1:0]  tmr [NUM_CH];
  logic [NUM_CH-1:0] hasPkt, fullElig, flushElig, elig;
  logic [2:0]        kEff;
  logic [NEED_W-1:0] need;

  logic [CH_W-1:0]   ptrQ, grantChan;
  logic              grantValid, doGrant;
  logic [7:0]        cnt;
  logic [2:0]        kQ, slotQ;
  logic [7:0]        pktLenQ;
  logic [REM_W-1:0]  remQ;
  logic              stuffQ;
  logic              hdrLast, byteLast, slotLast, slotReal, slotEnter, gapLast;

  logic              validQ, syncQ, endQ, stuffedQ;
  srcT               srcQ;
  logic [7:0]        nulQ, nulByte;

  // Eligibility from the live inputs; only the grant snapshot is held.
  always_comb begin
    // NOTE: every variable of a combinational block gets a value on every
    // path first, otherwise synthesis infers a latch.
    kEff = i_NumPkt;
    if (i_NumPkt == 3'd0)
      kEff = 3'd1;
    else if (int'(i_NumPkt) > MAX_PKTS)
      kEff = 3'(MAX_PKTS);
  end

  assign need = NEED_W'(kEff) * NEED_W'(i_PktLen);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign lvl[c]       = i_Level[c*LVL_W +: LVL_W];
    assign hasPkt[c]    = NEED_W'(lvl[c]) >= NEED_W'(i_PktLen);
    assign fullElig[c]  = NEED_W'(lvl[c]) >= need;
    assign flushElig[c] = (i_Timeout != '0) && (tmr[c] >= i_Timeout);
    // A channel holding less than one packet is never granted, even if a
    // stale timer value says otherwise.
    assign elig[c]      = hasPkt[c] && (fullElig[c] || flushElig[c]);
  end

  // Round-robin search starting at the channel after the last grant.
  always_comb begin
    int idx;
    idx        = 0;
    grantChan  = '0;
    grantValid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptrQ) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grantValid && elig[idx]) begin
        grantValid = 1'b1;
        grantChan  = CH_W'(idx);
      end
    end
  end

  assign doGrant   = (stateQ == IDLE) && i_Enable && grantValid;
  assign hdrLast   = (stateQ == HDR) && (cnt == 8'(HDR_LEN - 1));
  assign byteLast  = ((stateQ == PAY) || (stateQ == NUL)) && (cnt == pktLenQ - 8'd1);
  assign slotLast  = (slotQ == kQ - 3'd1);
  assign slotReal  = remQ >= REM_W'(pktLenQ);
  assign slotEnter = hdrLast || (byteLast && !slotLast);
  assign gapLast   = (stateQ == GAP) && (cnt == 8'(IFG - 1));

  // FSM: state register.
  always_ff @(posedge i_Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, regardless of block order.
    if (i_Rst) stateQ <= IDLE;
    else       stateQ <= stateNext;
  end

  // FSM: next state. Slots follow the header and each other with no bubble.
  always_comb begin
    stateNext = stateQ;
    unique case (stateQ)
      IDLE: if (doGrant) stateNext = HDR;
      HDR:  if (hdrLast) stateNext = slotReal ? PAY : NUL;
      PAY, NUL:
        if (byteLast) begin
          if (slotLast) stateNext = GAP;
          else          stateNext = slotReal ? PAY : NUL;
        end
      GAP:  if (gapLast) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FSM: request outputs.
  always_comb begin
    o_RdHdr   = (stateQ == HDR);
    o_HdrAddr = (stateQ == HDR) ? cnt[5:0] : 6'd0;
    o_RdPay   = '0;
    if (stateQ == PAY) o_RdPay[o_Chan] = 1'b1;
  end

  // Null packet: 0x47 sync, PID 0x1FFF, payload-only, then 0xFF stuffing.
  always_comb begin
    case (cnt)
      8'd0:    nulByte = 8'h47;
      8'd1:    nulByte = 8'h1F;
      8'd3:    nulByte = 8'h10;
      default: nulByte = 8'hFF;
    endcase
  end

  // Datapath: phase counter, grant snapshot, slot bookkeeping, flush timers.
  always_ff @(posedge i_Clk) begin
    // NOTE: reset is synchronous; every register, timers included, is
    // cleared so the pointer and counters start from a known state.
    if (i_Rst) begin
      cnt     <= '0;
      o_Chan  <= '0;
      ptrQ    <= '0;
      kQ      <= '0;
      pktLenQ <= '0;
      remQ    <= '0;
      slotQ   <= '0;
      stuffQ  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) tmr[c] <= '0;
    end else begin
      if ((stateQ == IDLE) || hdrLast || byteLast || gapLast) cnt <= '0;
      else                                                    cnt <= cnt + 8'd1;

      if (doGrant) begin
        o_Chan  <= grantChan;
        ptrQ    <= (grantChan == CH_W'(NUM_CH - 1)) ? '0 : grantChan + 1'b1;
        kQ      <= kEff;
        pktLenQ <= i_PktLen;
        remQ    <= REM_W'(lvl[grantChan]);
        slotQ   <= '0;
        stuffQ  <= 1'b0;
      end

      // Decide real vs null for the slot being entered.
      if (slotEnter) begin
        if (slotReal) remQ   <= remQ - REM_W'(pktLenQ);
        else          stuffQ <= 1'b1;
      end
      if (byteLast) slotQ <= slotQ + 3'd1;

      for (int c = 0; c < NUM_CH; c++) begin
        if ((doGrant && (grantChan == CH_W'(c))) || !hasPkt[c])
          tmr[c] <= '0;
        else if (!fullElig[c] && (tmr[c] != '1))
          tmr[c] <= tmr[c] + 1'b1;
      end
    end
  end

  // Output stage: request cycle delayed by one clock to meet RAM/FIFO q.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      validQ   <= 1'b0;
      syncQ    <= 1'b0;
      endQ     <= 1'b0;
      stuffedQ <= 1'b0;
      srcQ     <= SRC_NONE;
      nulQ     <= '0;
    end else begin
      validQ   <= (stateQ == HDR) || (stateQ == PAY) || (stateQ == NUL);
      syncQ    <= (stateQ == HDR) && (cnt == 8'd0);
      endQ     <= byteLast && slotLast;
      stuffedQ <= byteLast && slotLast && stuffQ;
      nulQ     <= nulByte;
      case (stateQ)
        HDR:     srcQ <= SRC_HDR;
        PAY:     srcQ <= SRC_PAY;
        NUL:     srcQ <= SRC_NUL;
        default: srcQ <= SRC_NONE;
      endcase
    end
  end

  always_comb begin
    case (srcQ)
      SRC_HDR: dgramOut.o_Data = i_HdrData;
      SRC_PAY: dgramOut.o_Data = i_PayData;
      SRC_NUL: dgramOut.o_Data = nulQ;
      default: dgramOut.o_Data = 8'h00;
    endcase
  end

  assign dgramOut.o_Valid   = validQ;
  assign dgramOut.o_Sync    = syncQ;
  assign dgramOut.o_End     = endQ;
  assign dgramOut.o_Stuffed = stuffedQ;

endmodule

// File: tb/tb_tsoip_dgram_sched.sv
// tb_tsoip_dgram_sched: directed scenarios plus a randomized datagram loop,
// checked against a packet-level reference model (header bytes, then K slots
// filled from the level snapshot, null packets for the shortfall).
module tb_tsoip_dgram_sched;
  localparam int NUM_CH   = 2;
  localparam int LVL_W    = 11;
  localparam int HDR_LEN  = 42;
  localparam int MAX_PKTS = 7;
  localparam int IFG      = 12;
  localparam int TMO_W    = 16;
  localparam int CH_W     = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic                    en;
  logic [2:0]              numPkt;
  logic [7:0]              pktLen;
  logic [TMO_W-1:0]        timeout;
  logic [NUM_CH*LVL_W-1:0] level;
  logic [7:0]              hdrQ = 8'h00;
  logic [7:0]              payQ = 8'h00;
  logic [CH_W-1:0]         chan;
  logic                    rdHdr;
  logic [5:0]              hdrAddr;
  logic [NUM_CH-1:0]       rdPay;

  tsoip_dgram_sched_if dgramIf ();

  tsoip_dgram_sched #(
    .NUM_CH(NUM_CH), .LVL_W(LVL_W), .HDR_LEN(HDR_LEN),
    .MAX_PKTS(MAX_PKTS), .IFG(IFG), .TMO_W(TMO_W)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_NumPkt(numPkt),
    .i_PktLen(pktLen), .i_Timeout(timeout), .i_Level(level),
    .i_HdrData(hdrQ), .i_PayData(payQ), .o_Chan(chan), .o_RdHdr(rdHdr),
    .o_HdrAddr(hdrAddr), .o_RdPay(rdPay), .dgramOut(dgramIf)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] expQ [$];
  bit  expStuff;
  int  expSeq  [NUM_CH] = '{default: 0};
  int  fifoSeq [NUM_CH] = '{default: 0};
  int  lastGrant;

  function automatic logic [7:0] hdr_byte(input int a);
    return 8'hC0 ^ 8'(a * 3);
  endfunction

  function automatic logic [7:0] pay_byte(input int c, input int n);
    return 8'(n * 7 + c * 91 + 1);
  endfunction

  function automatic logic [7:0] null_byte(input int b);
    case (b)
      0:       return 8'h47;
      1:       return 8'h1F;
      3:       return 8'h10;
      default: return 8'hFF;
    endcase
  endfunction

  // Header RAM and FIFOs, both with one cycle of read latency.
  always @(posedge clk) begin
    if (rdHdr) hdrQ <= hdr_byte(int'(hdrAddr));
    for (int c = 0; c < NUM_CH; c++)
      if (rdPay[c]) begin
        payQ       <= pay_byte(c, fifoSeq[c]);
        fifoSeq[c] <= fifoSeq[c] + 1;
      end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_level(input int c, input int v);
    level[c*LVL_W +: LVL_W] = LVL_W'(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) expSeq[c] = fifoSeq[c];
  endtask

  function automatic int eff_k(input int kraw);
    if (kraw == 0) return 1;
    if (kraw > MAX_PKTS) return MAX_PKTS;
    return kraw;
  endfunction

  // Expected datagram: header, then K slots drawn from the level snapshot.
  task automatic build_exp(input int ch, input int kraw, input int pl, input int snap);
    int rem;
    rem = snap;
    expQ.delete();
    expStuff = 1'b0;
    for (int h = 0; h < HDR_LEN; h++) expQ.push_back(hdr_byte(h));
    for (int s = 0; s < eff_k(kraw); s++) begin
      if (rem >= pl) begin
        for (int b = 0; b < pl; b++) begin
          expQ.push_back(pay_byte(ch, expSeq[ch]));
          expSeq[ch]++;
        end
        rem -= pl;
      end else begin
        expStuff = 1'b1;
        for (int b = 0; b < pl; b++) expQ.push_back(null_byte(b));
      end
    end
  endtask

  task automatic wait_sync(output bit ok);
    int n;
    n = 0;
    while (!(dgramIf.o_Valid && dgramIf.o_Sync) && n < 6000) begin
      tick();
      n++;
    end
    ok = dgramIf.o_Valid && dgramIf.o_Sync;
  endtask

  task automatic check_dgram(input string tag, input int ch, input int kraw, input int pl,
                             input int snap, input int dropAt, input bit scramble);
    bit ok;
    int n;
    build_exp(ch, kraw, pl, snap);
    wait_sync(ok);
    check({tag, " start"}, 64'(ok), 64'd1);
    if (!ok) return;
    check({tag, " chan"}, 64'(chan), 64'(ch));
    n = expQ.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s byte%0d", tag, i),
            64'({dgramIf.o_Valid, dgramIf.o_Sync, dgramIf.o_End, dgramIf.o_Stuffed, dgramIf.o_Data}),
            64'({1'b1, 1'(i == 0), 1'(i == n - 1), 1'((i == n - 1) && expStuff), expQ[i]}));
      if (i == dropAt) en = 1'b0;
      // Inputs moving mid-datagram must not disturb it.
      if (scramble && i == 100) begin
        pktLen = 8'($urandom);
        numPkt = 3'($urandom);
        for (int c = 0; c < NUM_CH; c++) set_level(c, int'($urandom_range(0, 2047)));
      end
      tick();
    end
    check({tag, " trailing"}, 64'(dgramIf.o_Valid), 64'd0);
  endtask

  // Valid-low cycles between o_End and the next o_Sync: IFG cycles of GAP
  // plus the IDLE arbitration cycle.
  task automatic check_gap(input string tag);
    int n;
    n = 0;
    while (!(dgramIf.o_Valid && dgramIf.o_Sync) && n < 200) begin
      n++;
      tick();
    end
    check(tag, 64'(n), 64'(IFG + 1));
  endtask

  initial begin
    bit ok;
    int n;
    int kraw, pl, pred, keff;
    int lv [NUM_CH];

    rst = 1'b1; en = 1'b0; numPkt = 3'd7; pktLen = 8'd188;
    timeout = '0; level = '0;
    repeat (3) tick();
    check("reset outputs",
          64'({dgramIf.o_Valid, dgramIf.o_Sync, dgramIf.o_End, dgramIf.o_Stuffed,
               dgramIf.o_Data, chan, rdHdr, hdrAddr, rdPay}), 64'd0);

    // Single full channel: K=7 x 188 from level 1316.
    set_level(0, 1316);
    en  = 1'b1;
    rst = 1'b0;
    check_dgram("full1", 0, 7, 188, 1316, -1, 1'b0);
    check_gap("full1 gap");
    check_dgram("full2", 0, 7, 188, 1316, -1, 1'b0);
    en = 1'b0;

    // Two full channels alternate; reset mid-datagram of the sixth.
    set_level(0, 1500);
    set_level(1, 1500);
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_dgram($sformatf("rr%0d", i), i % 2, 7, 188, 1500, -1, 1'b0);
      check_gap($sformatf("rr%0d gap", i));
    end
    check("rr5 chan", 64'(chan), 64'd1);
    repeat (499) tick();
    check("rr5 byte500 valid", 64'(dgramIf.o_Valid), 64'd1);
    rst = 1'b1;
    tick();
    check("rst cut", 64'({dgramIf.o_Valid, dgramIf.o_End, chan, rdHdr, rdPay}), 64'd0);
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) expSeq[c] = fifoSeq[c];
    check_dgram("after rst", 0, 7, 188, 1500, -1, 1'b0);
    en = 1'b0;

    // Flush timeout: 400 bytes gives two real and five null packets.
    level   = '0;
    timeout = TMO_W'(100);
    do_reset();
    set_level(0, 400);
    en = 1'b1;
    n  = 0;
    while (!rdHdr && n < 300) begin
      tick();
      n++;
    end
    // Timer reaches 100 after 100 edges; the grant edge is the next one.
    check("flush latency", 64'(n), 64'd101);
    check_dgram("flush", 0, 7, 188, 400, -1, 1'b0);

    // Timeout disabled: a partial channel is never granted.
    timeout = '0;
    n = 0;
    repeat (10000) begin
      tick();
      if (rdHdr || dgramIf.o_Valid) n++;
    end
    check("no flush", 64'(n), 64'd0);
    en = 1'b0;

    // K=0 behaves as 1; enable drops at byte 10.
    set_level(0, 2000);
    numPkt = 3'd0;
    pktLen = 8'd204;
    do_reset();
    en = 1'b1;
    check_dgram("k0", 0, 0, 204, 2000, 10, 1'b0);
    n = 0;
    repeat (500) begin
      tick();
      if (dgramIf.o_Sync) n++;
    end
    check("k0 no regrant", 64'(n), 64'd0);

    // Randomized datagrams with full eligibility only.
    do_reset();
    lastGrant = NUM_CH - 1;
    for (int it = 0; it < 10; it++) begin
      kraw = int'($urandom_range(0, 7));
      pl   = int'($urandom_range(150, 255));
      keff = eff_k(kraw);
      for (int c = 0; c < NUM_CH; c++) lv[c] = int'($urandom_range(0, 2047));
      if (lv[0] < keff * pl && lv[1] < keff * pl) begin
        pred     = int'($urandom_range(0, NUM_CH - 1));
        lv[pred] = keff * pl + int'($urandom_range(0, 2047 - keff * pl));
      end
      pred = -1;
      for (int i = 1; i <= NUM_CH; i++)
        if (pred < 0 && lv[(lastGrant + i) % NUM_CH] >= keff * pl)
          pred = (lastGrant + i) % NUM_CH;
      lastGrant = pred;
      numPkt = 3'(kraw);
      pktLen = 8'(pl);
      for (int c = 0; c < NUM_CH; c++) set_level(c, lv[c]);
      en = 1'b1;
      check_dgram($sformatf("rnd%0d", it), pred, kraw, pl, lv[pred], -1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
